// File: rtl/param_priority_encoder_pkg.sv
// Shared constants and width helper for the parameterised priority encoder.
package pe_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for an n-entry request vector, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/param_priority_encoder_if.sv
// Request/result handshake bundle between producer, encoder and consumer.
interface param_priority_encoder_if
  import pe_pkg::*;
#(
  parameter int unsigned N = 8
) ();

  localparam int unsigned W = idx_width(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] req;
  logic         rr_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] idx;
  logic [N-1:0] onehot;
  logic         none;

  modport master (
    output in_valid, req, rr_en, out_ready,
    input  in_ready, out_valid, idx, onehot, none
  );

  modport slave (
    input  in_valid, req, rr_en, out_ready,
    output in_ready, out_valid, idx, onehot, none
  );

endinterface

// File: rtl/param_priority_encoder_lsb_find.sv
// Combinational lowest-set-bit finder: index, one-hot and any-set flag.
module lsb_find
  import pe_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         found
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign onehot = vec & (~vec + N'(1));
  assign found  = |vec;

endmodule

// File: rtl/param_priority_encoder.sv
// Fixed / round-robin priority encoder with a one-entry registered result.
module param_priority_encoder
  import pe_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  param_priority_encoder_if.slave bus
);

  localparam int unsigned W = idx_width(N);

  logic [W-1:0] ptr;
  logic [N-1:0] mask;
  logic [N-1:0] masked_req;

  logic [W-1:0] m_idx, f_idx, win_idx, ptr_next;
  logic [N-1:0] m_onehot, f_onehot, win_onehot;
  logic         m_found, f_found;
  logic         rr_mode, accept, ready;

  logic         valid_q, none_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] onehot_q;

  // Keep only requesters at or above the round-robin pointer.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(N); i++) begin
      mask[i] = (W'(i) >= ptr);
    end
  end

  assign masked_req = bus.req & mask;

  lsb_find #(.N(N)) u_masked (
    .vec    (masked_req),
    .idx    (m_idx),
    .onehot (m_onehot),
    .found  (m_found)
  );

  lsb_find #(.N(N)) u_full (
    .vec    (bus.req),
    .idx    (f_idx),
    .onehot (f_onehot),
    .found  (f_found)
  );

  // Masked search wins in round-robin mode; otherwise fall back to wrap-around.
  always_comb begin
    rr_mode    = (bus.rr_en == MODE_RR);
    win_idx    = f_idx;
    win_onehot = f_onehot;
    if (rr_mode && m_found) begin
      win_idx    = m_idx;
      win_onehot = m_onehot;
    end
    ptr_next = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
  end

  assign ready  = !valid_q || bus.out_ready;
  assign accept = bus.in_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      none_q   <= 1'b0;
      ptr      <= '0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      idx_q    <= f_found ? win_idx : '0;
      onehot_q <= f_found ? win_onehot : '0;
      none_q   <= !f_found;
      if (rr_mode && f_found) ptr <= ptr_next;
    end else if (valid_q && bus.out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.idx       = idx_q;
  assign bus.onehot    = onehot_q;
  assign bus.none      = none_q;

endmodule

// File: doc/param_priority_encoder.md
PARAM_PRIORITY_ENCODER -- requirements
Module: param_priority_encoder

Interface
REQ-001 SHALL have parameter N, default 8: number of request inputs, legal range 2..64, power of two not required.
REQ-002 SHALL have derived localparam W = max(1, clog2(N)): index width.
REQ-003 SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  request vector on req is offered.
REQ-007 in_ready  output  1  block can accept req this cycle.
REQ-008 req  input  N  request bits, bit i = requester i.
REQ-009 rr_en  input  1  0 = fixed priority, 1 = round-robin; sampled only on accept.
REQ-010 out_valid  output  1  idx/onehot/none hold a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 idx  output  W  encoded winner index.
REQ-013 onehot  output  N  one-hot winner, all zeros when no request.
REQ-014 none  output  1  accepted req was all zeros.

Function
REQ-015 Accept SHALL occur when in_valid && in_ready; drain SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready (combinational, one-entry output register, full throughput).
REQ-017 Latency SHALL be exactly 1 cycle: result visible on the clock edge following accept.
REQ-018 On accept, out_valid SHALL be set; on drain without accept, out_valid SHALL clear; accept and drain in the same cycle SHALL keep out_valid=1 with new result.
REQ-019 While out_valid && !out_ready, idx/onehot/none SHALL hold stable.
REQ-020 Fixed mode: winner SHALL be the lowest set index of req.
REQ-021 Round-robin mode: winner SHALL be the first set bit searching upward from ptr, wrapping from N-1 to 0.
REQ-022 Internal pointer ptr (W bits, range 0..N-1) SHALL update to (winner+1) mod N only on accept with rr_en=1 and req nonzero; wrap SHALL occur at N, not 2^W.
REQ-023 Fixed-mode accepts SHALL leave ptr unchanged.
REQ-024 req all zero on accept: idx=0, onehot=0, none=1, ptr unchanged, in either mode.
REQ-025 req nonzero: none=0, onehot has exactly one bit set, onehot[idx]=1.
REQ-026 in_valid=0 cycles SHALL not change ptr or outputs.
REQ-027 Bits of req above N-1 do not exist; no X propagation from unused index codes when N is not a power of two.

Reset
REQ-028 rst_n low SHALL immediately force out_valid=0, idx=0, onehot=0, none=0, ptr=0 regardless of clk.
REQ-029 Reset mid-transaction SHALL discard the held result; first accept after release SHALL behave as from power-on.
REQ-030 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-031 Package pe_pkg SHALL hold the clog2-based width function and the mode encoding constants (MODE_FIXED=0, MODE_RR=1).
REQ-032 One sub-module lsb_find (parameter N, combinational: vector in, lowest-set index, one-hot, found) SHALL be instantiated twice: on req masked to bits >= ptr and on unmasked req; masked result wins if found.
REQ-033 Target size 120-400 lines RTL total.

Verification
REQ-034 N=4, fixed, out_ready=1: req 0001,0010,0100,1000 in consecutive cycles -> idx 0,1,2,3 one cycle later each, none=0.
REQ-035 N=4, rr_en=1, req=1111 held for 5 accepts -> idx 0,1,2,3,0 (wrap), onehot 0001,0010,0100,1000,0001.
REQ-036 N=5, rr_en=1, req=10001 repeatedly -> idx 0,4,0,4; ptr never reaches 5..7.
REQ-037 out_ready=0 for 3 cycles after one accept of req=0110 -> in_ready=0, idx=1 held, second offered req not accepted until out_ready=1.
REQ-038 req=0000 accept -> none=1, onehot=0, idx=0; following rr accept of 1111 from ptr=2 -> idx=2 (ptr unchanged by empty request).
REQ-039 Assert rst_n=0 mid-cycle while out_valid=1 and ptr=3 -> out_valid=0 at once; after release, rr req=1111 -> idx=0; 100 random req/rr_en/out_ready cycles checked against a reference model.
